// File: rtl/lod_normalizer_pipe.sv
// ---------------------------------------------------------------------------
// lod_normalizer_pipe
//
// Two-stage pipelined leading-one detector and normaliser for the softmax
// log2 path. For each input word it reports the 1-based position of the
// highest set bit (0 for an all-zero word) and a zero flag. It also reports
// the fraction bits found below the leading one, MSB-aligned, so that a log2
// LUT or interpolator can consume them directly. A sideband tag travels with
// every word, which lets several softmax channels share one instance.
//
// Ports
//   clk        in   1          clock, rising edge
//   rst        in   1          asynchronous reset, active low
//   in_valid   in   1          input word valid
//   in_ready   out  1          block can accept an input word this cycle
//   in_data    in   IN_SIZE    unsigned input word
//   in_tag     in   TAG_SIZE   sideband tag (channel / row id)
//   out_valid  out  1          result valid
//   out_ready  in   1          downstream accepts the result this cycle
//   out_pos    out  POS_SIZE   1-based index of highest '1' (bit k -> k+1), 0 if zero
//   out_zero   out  1          1 iff the input word was zero
//   out_frac   out  FRAC_SIZE  bits below the leading one, MSB-aligned, zero-padded
//   out_tag    out  TAG_SIZE   tag belonging to this result
//
// Pipeline
//   S1 registers the word, its tag and the one-hot mask of its highest set
//   bit. S2 registers the encoded position, zero flag, fraction and tag; the
//   S2 registers drive the out_* ports directly. With out_ready held high an
//   accepted word shows up on out_valid exactly two cycles later, and the
//   pipe sustains one word per cycle.
//
//   Flow control is a plain combinational ready chain without a skid buffer:
//     adv2 = ~s2_valid | out_ready
//     adv1 = ~s1_valid | adv2
//     in_ready = adv1
//   A stage that cannot advance holds both its data and its valid bit.
//   Because of this, out_* stay stable while a result is stalled.
// ---------------------------------------------------------------------------
module lod_normalizer_pipe #(
  parameter int IN_SIZE   = 32,
  parameter int POS_SIZE  = $clog2(IN_SIZE) + 1,
  parameter int FRAC_SIZE = 16,
  parameter int TAG_SIZE  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_SIZE-1:0]   in_data,
  input  logic [TAG_SIZE-1:0]  in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [POS_SIZE-1:0]  out_pos,
  output logic                 out_zero,
  output logic [FRAC_SIZE-1:0] out_frac,
  output logic [TAG_SIZE-1:0]  out_tag
);

  // The fraction is taken from the bits below the leading one with
  // FRAC_SIZE zeros appended. The appended zeros pad the result when the
  // word has fewer than FRAC_SIZE bits below the leading one. Bits beyond
  // FRAC_SIZE are truncated without rounding.
  localparam int EXT_SIZE = IN_SIZE - 1 + FRAC_SIZE;

  // -------------------------------------------------------------------------
  // Flow control
  // -------------------------------------------------------------------------
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic adv1;
  logic adv2;

  assign adv2      = ~s2_valid_reg | out_ready;
  assign adv1      = ~s1_valid_reg | adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid_reg;

  // -------------------------------------------------------------------------
  // Stage 1 combinational: one-hot of the highest set bit
  //   above_in[i] = OR of every input bit strictly above bit i
  //   one_hot[i]  = in_data[i] & ~above_in[i]
  // Each bit depends only on the input word. No bit depends on a
  // neighbouring result, so no priority chain is needed.
  // -------------------------------------------------------------------------
  logic [IN_SIZE-1:0] above_in;
  logic [IN_SIZE-1:0] one_hot_next;

  generate
    for (genvar gi = 0; gi < IN_SIZE; gi++) begin : g_one_hot
      if (gi == IN_SIZE - 1) begin : g_top
        assign above_in[gi] = 1'b0;
      end else begin : g_lower
        assign above_in[gi] = |in_data[IN_SIZE-1:gi+1];
      end
      assign one_hot_next[gi] = in_data[gi] & ~above_in[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Stage 1 registers
  // -------------------------------------------------------------------------
  logic [IN_SIZE-1:0]  s1_data_reg;
  logic [TAG_SIZE-1:0] s1_tag_reg;
  logic [IN_SIZE-1:0]  s1_one_hot_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg   <= 1'b0;
      s1_data_reg    <= '0;
      s1_tag_reg     <= '0;
      s1_one_hot_reg <= '0;
    end else if (adv1) begin
      s1_valid_reg <= in_valid;
      // The payload is only loaded for real words. A bubble therefore leaves
      // the previous contents in place and saves needless toggling.
      if (in_valid) begin
        s1_data_reg    <= in_data;
        s1_tag_reg     <= in_tag;
        s1_one_hot_reg <= one_hot_next;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2 combinational: encode the position and normalise the word.
  // Every one-hot bit selects its own candidate, and the candidates are
  // ORed together. Since at most one bit is set, the OR behaves as a clean
  // mux. This gives an exact encoding with no priority ambiguity.
  //   pos_cand[i]  = i+1                        when one_hot[i]
  //   norm_cand[i] = data << (IN_SIZE-1-i)      when one_hot[i]
  // The shift moves the leading one up to bit IN_SIZE-1.
  // -------------------------------------------------------------------------
  logic [POS_SIZE-1:0] pos_cand  [IN_SIZE];
  logic [IN_SIZE-1:0]  norm_cand [IN_SIZE];

  generate
    for (genvar gi = 0; gi < IN_SIZE; gi++) begin : g_cand
      localparam int SHIFT = IN_SIZE - 1 - gi;
      assign pos_cand[gi]  = s1_one_hot_reg[gi] ? POS_SIZE'(gi + 1) : '0;
      assign norm_cand[gi] = s1_one_hot_reg[gi] ? (s1_data_reg << SHIFT) : '0;
    end
  endgenerate

  logic [POS_SIZE-1:0]  s2_pos_next;
  logic [IN_SIZE-1:0]   s2_norm_next;
  logic                 s2_zero_next;
  logic [EXT_SIZE-1:0]  s2_ext_next;
  logic [FRAC_SIZE-1:0] s2_frac_next;

  always_comb begin
    s2_pos_next  = '0;
    s2_norm_next = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      s2_pos_next  = s2_pos_next  | pos_cand[i];
      s2_norm_next = s2_norm_next | norm_cand[i];
    end
  end

  // An all-zero word has an empty one-hot mask. In that case the position
  // and the normalised word both collapse to zero on their own.
  assign s2_zero_next = ~|s1_one_hot_reg;

  // The leading one itself (s2_norm_next[IN_SIZE-1]) is implied and is
  // dropped. The remaining bits are MSB-aligned into the fraction.
  assign s2_ext_next  = {s2_norm_next[IN_SIZE-2:0], {FRAC_SIZE{1'b0}}};
  assign s2_frac_next = s2_ext_next[EXT_SIZE-1 -: FRAC_SIZE];

  // These bits are removed on purpose: the implied leading one and the
  // truncated tail.
  logic unused_bits;
  assign unused_bits = ^{s2_norm_next[IN_SIZE-1], s2_ext_next[EXT_SIZE-FRAC_SIZE-1:0]};

  // -------------------------------------------------------------------------
  // Stage 2 registers (drive the out_* ports)
  // -------------------------------------------------------------------------
  logic [POS_SIZE-1:0]  s2_pos_reg;
  logic                 s2_zero_reg;
  logic [FRAC_SIZE-1:0] s2_frac_reg;
  logic [TAG_SIZE-1:0]  s2_tag_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_reg <= 1'b0;
      s2_pos_reg   <= '0;
      s2_zero_reg  <= 1'b0;
      s2_frac_reg  <= '0;
      s2_tag_reg   <= '0;
    end else if (adv2) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_pos_reg  <= s2_pos_next;
        s2_zero_reg <= s2_zero_next;
        s2_frac_reg <= s2_frac_next;
        s2_tag_reg  <= s1_tag_reg;
      end
    end
  end

  assign out_pos  = s2_pos_reg;
  assign out_zero = s2_zero_reg;
  assign out_frac = s2_frac_reg;
  assign out_tag  = s2_tag_reg;

endmodule
